// File: rtl/bg_region_redraw.sv
// Sequential background redraw engine: walks a latched rectangle in raster order,
// reads the shared background ROMs and streams (x, y, colour) plots with backpressure.
module bg_region_redraw #(
   parameter int H_RES   = 320,
   parameter int V_RES   = 240,
   parameter int X_W     = 9,
   parameter int Y_W     = 8,
   parameter int ADDR_W  = 17,
   parameter int COLOR_W = 3,
   parameter int NUM_BG  = 3,
   parameter int SEL_W   = 2
) (
   input  logic                      clock,
   input  logic                      resetn,
   input  logic                      start,
   input  logic [SEL_W-1:0]          bg_sel,
   input  logic [X_W-1:0]            x0,
   input  logic [Y_W-1:0]            y0,
   input  logic [X_W-1:0]            x1,
   input  logic [Y_W-1:0]            y1,
   output logic [ADDR_W-1:0]         rom_address,
   output logic                      rom_clken,
   input  logic [NUM_BG*COLOR_W-1:0] rom_q,
   output logic                      plot,
   input  logic                      plot_ready,
   output logic [X_W-1:0]            plot_x,
   output logic [Y_W-1:0]            plot_y,
   output logic [COLOR_W-1:0]        plot_color,
   output logic                      busy,
   output logic                      done
);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FINISH} state_t;

   localparam logic [X_W-1:0] X_MAX = X_W'(H_RES - 1);
   localparam logic [Y_W-1:0] Y_MAX = Y_W'(V_RES - 1);

   state_t state, state_next;

   logic [SEL_W-1:0]   bg_sel_lat;
   logic [X_W-1:0]     x0_lat, x1_lat, cx, b_x;
   logic [Y_W-1:0]     y1_lat, cy, b_y;
   logic               b_valid;
   logic [X_W-1:0]     x1_clamp;
   logic [Y_W-1:0]     y1_clamp;
   logic               rect_empty;
   logic               advance;
   logic               last_issue;
   logic [COLOR_W-1:0] sel_color;

   assign x1_clamp    = (x1 > X_MAX) ? X_MAX : x1;
   assign y1_clamp    = (y1 > Y_MAX) ? Y_MAX : y1;
   assign rect_empty  = (x0 > x1_clamp) || (y0 > y1_clamp);
   assign advance     = !plot || plot_ready;
   assign last_issue  = (cx == x1_lat) && (cy == y1_lat);
   assign rom_clken   = advance;
   assign rom_address = ADDR_W'(cy) * ADDR_W'(H_RES) + ADDR_W'(cx);
   assign busy        = (state == SCAN) || (state == DRAIN);
   assign done        = (state == FINISH);

   // Out-of-range background indices fall back to background 0
   always_comb begin
      sel_color = rom_q[0 +: COLOR_W];
      for (int i = 1; i < NUM_BG; i++) begin
         if (bg_sel_lat == SEL_W'(i)) sel_color = rom_q[i*COLOR_W +: COLOR_W];
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = rect_empty ? FINISH : SCAN;
         SCAN:    if (advance && last_issue) state_next = DRAIN;
         DRAIN:   if (!b_valid && advance) state_next = FINISH;
         FINISH:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Counters, stage B and the output stage all move together on advance,
   // while rom_clken freezes rom_q so it stays aligned with stage B during a stall
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         bg_sel_lat <= '0;
         x0_lat     <= '0;
         x1_lat     <= '0;
         y1_lat     <= '0;
         cx         <= '0;
         cy         <= '0;
         b_valid    <= 1'b0;
         b_x        <= '0;
         b_y        <= '0;
         plot       <= 1'b0;
         plot_x     <= '0;
         plot_y     <= '0;
         plot_color <= '0;
      end else begin
         if (state == IDLE && start) begin
            bg_sel_lat <= bg_sel;
            x0_lat     <= x0;
            x1_lat     <= x1_clamp;
            y1_lat     <= y1_clamp;
            cx         <= x0;
            cy         <= y0;
         end else if (state == SCAN && advance) begin
            if (cx == x1_lat) begin
               if (cy != y1_lat) begin
                  cx <= x0_lat;
                  cy <= cy + 1'b1;
               end
            end else begin
               cx <= cx + 1'b1;
            end
         end
         if (advance) begin
            plot       <= b_valid;
            plot_x     <= b_x;
            plot_y     <= b_y;
            plot_color <= sel_color;
            b_valid    <= (state == SCAN);
            b_x        <= cx;
            b_y        <= cy;
         end
      end
   end

endmodule

// File: tb/tb_bg_region_redraw.sv
// Self-checking bench for bg_region_redraw: a registered ROM model plus a raster-order
// pixel list built from the rectangle rules, compared against the accepted plot stream.
module tb_bg_region_redraw;

   typedef struct packed {
      logic [8:0] x;
      logic [7:0] y;
      logic [2:0] c;
   } pix_t;

   logic        clock = 1'b0;
   logic        resetn;
   logic        start;
   logic [1:0]  bg_sel;
   logic [8:0]  x0, x1;
   logic [7:0]  y0, y1;
   logic [16:0] rom_address;
   logic        rom_clken;
   logic [8:0]  rom_q = '0;
   logic        plot;
   logic        plot_ready;
   logic [8:0]  plot_x;
   logic [7:0]  plot_y;
   logic [2:0]  plot_color;
   logic        busy;
   logic        done;

   pix_t        exp_q[$];
   pix_t        acc_q[$];
   logic [16:0] issue_q[$];

   int checks = 0;
   int errors = 0;
   int rom_mode = 0;
   bit capture_on = 1'b0;
   int first_plot_cyc, first_done_cyc, done_cyc, last_acc_cyc, done_count;
   int stall_err, clken_err, busy_err, busy_seen;
   logic [1:0] ch_sel;
   int ch_x0, ch_y0, ch_x1, ch_y1;

   bg_region_redraw dut (
      .clock(clock), .resetn(resetn), .start(start), .bg_sel(bg_sel),
      .x0(x0), .y0(y0), .x1(x1), .y1(y1),
      .rom_address(rom_address), .rom_clken(rom_clken), .rom_q(rom_q),
      .plot(plot), .plot_ready(plot_ready), .plot_x(plot_x), .plot_y(plot_y),
      .plot_color(plot_color), .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   // Mode 0: each background is a distinct constant; mode 1: colour derived from address
   function automatic logic [2:0] rom_fn(input int bg, input int addr);
      if (rom_mode == 0) return 3'(2 * bg + 1);
      return 3'(addr + (addr >> 4) + 3 * bg);
   endfunction

   // Registered ROM model with clock enable; also records each distinct address it captures
   always @(posedge clock) begin
      if (rom_clken) begin
         for (int i = 0; i < 3; i++) rom_q[i*3 +: 3] <= rom_fn(i, int'(rom_address));
      end
      if (capture_on && rom_clken && busy &&
          (issue_q.size() == 0 || issue_q[$] != rom_address))
         issue_q.push_back(rom_address);
   end

   // Appends the raster-order pixels of the clamped rectangle to exp_q
   function automatic void build_expected(input int sel, input int rx0, input int ry0,
                                          input int rx1, input int ry1);
      int   ex1, ey1, eb;
      pix_t p;
      ex1 = (rx1 > 319) ? 319 : rx1;
      ey1 = (ry1 > 239) ? 239 : ry1;
      eb  = (sel < 3) ? sel : 0;
      for (int y = ry0; y <= ey1; y++) begin
         for (int x = rx0; x <= ex1; x++) begin
            p.x = 9'(x);
            p.y = 8'(y);
            p.c = rom_fn(eb, y * 320 + x);
            exp_q.push_back(p);
         end
      end
   endfunction

   // Starts a redraw and records the accepted plot stream and timing/protocol statistics
   task automatic do_redraw(input int sel, input int rx0, input int ry0, input int rx1,
                            input int ry1, input int ready_pct, input int inj_cycle,
                            input int chain, input int max_cycles);
      int   target;
      bit   chain_go, prev_stall, nonempty;
      pix_t prev, cur;
      target = (chain != 0) ? 2 : 1;
      nonempty = (rx0 <= ((rx1 > 319) ? 319 : rx1)) && (ry0 <= ((ry1 > 239) ? 239 : ry1));
      chain_go = 1'b0; prev_stall = 1'b0; prev = '0;
      acc_q.delete(); issue_q.delete();
      first_plot_cyc = -1; first_done_cyc = -1; done_cyc = -1; last_acc_cyc = -1;
      done_count = 0; stall_err = 0; clken_err = 0; busy_err = 0; busy_seen = 0;
      @(negedge clock);
      bg_sel = 2'(sel); x0 = 9'(rx0); y0 = 8'(ry0); x1 = 9'(rx1); y1 = 8'(ry1);
      start = 1'b1; plot_ready = 1'b1; capture_on = 1'b1;
      @(posedge clock); #1;
      for (int c = 0; c < max_cycles; c++) begin
         if (c > 0) begin @(posedge clock); #1; end
         start = 1'b0;
         bg_sel = 2'($urandom); x0 = 9'($urandom); y0 = 8'($urandom);
         x1 = 9'($urandom); y1 = 8'($urandom);
         if (c == inj_cycle) start = 1'b1;
         if (chain_go) begin
            start = 1'b1; bg_sel = ch_sel;
            x0 = 9'(ch_x0); y0 = 8'(ch_y0); x1 = 9'(ch_x1); y1 = 8'(ch_y1);
            chain_go = 1'b0;
         end else if (chain != 0 && done === 1'b1 && done_count == 0) begin
            start = 1'b1;
            chain_go = 1'b1;
         end
         plot_ready = (int'($urandom_range(99)) < ready_pct);
         #1;
         cur.x = plot_x; cur.y = plot_y; cur.c = plot_color;
         if (rom_clken !== !(plot && !plot_ready)) clken_err++;
         if (prev_stall && (plot !== 1'b1 || cur !== prev)) stall_err++;
         prev_stall = (plot === 1'b1) && !plot_ready;
         prev = cur;
         if (plot === 1'b1 && first_plot_cyc < 0) first_plot_cyc = c;
         if (plot === 1'b1 && plot_ready) begin
            acc_q.push_back(cur);
            last_acc_cyc = c;
         end
         if (busy === 1'b1) busy_seen = 1;
         if (done === 1'b1) begin
            done_count++;
            done_cyc = c;
            if (first_done_cyc < 0) first_done_cyc = c;
            if (busy !== 1'b0) busy_err++;
         end else if (first_done_cyc < 0 && nonempty && busy !== 1'b1) begin
            busy_err++;
         end
         if (done_count >= target && c >= done_cyc + 2) break;
      end
      start = 1'b0; capture_on = 1'b0; plot_ready = 1'b1;
   endtask

   task automatic test_reset();
      resetn = 1'b0; start = 1'b0; plot_ready = 1'b1;
      bg_sel = '0; x0 = '0; y0 = '0; x1 = '0; y1 = '0;
      repeat (3) @(posedge clock);
      #2;
      checks++; if (plot !== 1'b0) begin errors++; $display("[TB] FAIL reset plot: got %b expected 0", plot); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset done: got %b expected 0", done); end
      checks++; if (rom_clken !== 1'b1) begin errors++; $display("[TB] FAIL reset rom_clken: got %b expected 1", rom_clken); end
      checks++; if (rom_address !== 17'd0) begin errors++; $display("[TB] FAIL reset rom_address: got %0d expected 0", rom_address); end
      checks++;
      if (plot_x !== 9'd0 || plot_y !== 8'd0 || plot_color !== 3'd0) begin
         errors++;
         $display("[TB] FAIL reset plot outputs: got (%0d,%0d,%0d) expected (0,0,0)", plot_x, plot_y, plot_color);
      end
      @(negedge clock);
      resetn = 1'b1;
   endtask

   task automatic test_full_screen();
      rom_mode = 1;
      exp_q.delete();
      build_expected(0, 0, 0, 319, 239);
      do_redraw(0, 0, 0, 319, 239, 100, -1, 0, 80000);
      checks++; if (acc_q.size() != 76800) begin errors++; $display("[TB] FAIL full count: got %0d expected 76800", acc_q.size()); end
      foreach (exp_q[i]) begin
         pix_t g;
         g = (i < acc_q.size()) ? acc_q[i] : '1;
         checks++;
         if (g !== exp_q[i]) begin
            errors++;
            if (errors <= 10) $display("[TB] FAIL full pixel %0d: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)", i, g.x, g.y, g.c, exp_q[i].x, exp_q[i].y, exp_q[i].c);
         end
      end
      checks++; if (first_plot_cyc != 2) begin errors++; $display("[TB] FAIL full first plot latency: got %0d expected 2", first_plot_cyc); end
      checks++; if (issue_q.size() != 76800) begin errors++; $display("[TB] FAIL full issued addresses: got %0d expected 76800", issue_q.size()); end
      checks++;
      if (issue_q.size() == 0 || issue_q[$] !== 17'd76799) begin
         errors++;
         $display("[TB] FAIL full last address: got %0d expected 76799", (issue_q.size() == 0) ? -1 : int'(issue_q[$]));
      end
      checks++; if (first_done_cyc != last_acc_cyc + 1) begin errors++; $display("[TB] FAIL full done timing: got %0d expected %0d", first_done_cyc, last_acc_cyc + 1); end
      checks++; if (done_count != 1) begin errors++; $display("[TB] FAIL full done pulses: got %0d expected 1", done_count); end
      checks++; if (busy_err != 0) begin errors++; $display("[TB] FAIL full busy window: got %0d bad cycles expected 0", busy_err); end
   endtask

   task automatic test_region_select();
      int exp_addr[6] = '{1610, 1611, 1612, 1930, 1931, 1932};
      rom_mode = 0;
      exp_q.delete();
      build_expected(2, 10, 5, 12, 6);
      do_redraw(2, 10, 5, 12, 6, 100, -1, 0, 200);
      checks++; if (acc_q.size() != 6) begin errors++; $display("[TB] FAIL region count: got %0d expected 6", acc_q.size()); end
      foreach (exp_q[i]) begin
         pix_t g;
         g = (i < acc_q.size()) ? acc_q[i] : '1;
         checks++;
         if (g !== exp_q[i]) begin
            errors++;
            $display("[TB] FAIL region pixel %0d: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)", i, g.x, g.y, g.c, exp_q[i].x, exp_q[i].y, exp_q[i].c);
         end
      end
      checks++; if (issue_q.size() != 6) begin errors++; $display("[TB] FAIL region address count: got %0d expected 6", issue_q.size()); end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (i >= issue_q.size() || int'(issue_q[i]) != exp_addr[i]) begin
            errors++;
            $display("[TB] FAIL region address %0d: got %0d expected %0d", i, (i < issue_q.size()) ? int'(issue_q[i]) : -1, exp_addr[i]);
         end
      end
      checks++; if (first_done_cyc != last_acc_cyc + 1) begin errors++; $display("[TB] FAIL region done timing: got %0d expected %0d", first_done_cyc, last_acc_cyc + 1); end
   endtask

   task automatic test_backpressure();
      rom_mode = 1;
      exp_q.delete();
      build_expected(1, 100, 50, 103, 53);
      do_redraw(1, 100, 50, 103, 53, 50, -1, 0, 600);
      checks++; if (acc_q.size() != 16) begin errors++; $display("[TB] FAIL bp count: got %0d expected 16", acc_q.size()); end
      foreach (exp_q[i]) begin
         pix_t g;
         g = (i < acc_q.size()) ? acc_q[i] : '1;
         checks++;
         if (g !== exp_q[i]) begin
            errors++;
            $display("[TB] FAIL bp pixel %0d: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)", i, g.x, g.y, g.c, exp_q[i].x, exp_q[i].y, exp_q[i].c);
         end
      end
      checks++; if (stall_err != 0) begin errors++; $display("[TB] FAIL bp stall stability: got %0d unstable cycles expected 0", stall_err); end
      checks++; if (clken_err != 0) begin errors++; $display("[TB] FAIL bp rom_clken: got %0d wrong cycles expected 0", clken_err); end
      checks++; if (first_done_cyc != last_acc_cyc + 1) begin errors++; $display("[TB] FAIL bp done timing: got %0d expected %0d", first_done_cyc, last_acc_cyc + 1); end
      checks++; if (done_count != 1) begin errors++; $display("[TB] FAIL bp done pulses: got %0d expected 1", done_count); end
   endtask

   task automatic test_boundaries();
      rom_mode = 1;
      exp_q.delete();
      build_expected(0, 318, 238, 400, 255);
      do_redraw(0, 318, 238, 400, 255, 70, -1, 0, 300);
      checks++; if (acc_q.size() != 4) begin errors++; $display("[TB] FAIL clamp count: got %0d expected 4", acc_q.size()); end
      foreach (exp_q[i]) begin
         pix_t g;
         g = (i < acc_q.size()) ? acc_q[i] : '1;
         checks++;
         if (g !== exp_q[i]) begin
            errors++;
            $display("[TB] FAIL clamp pixel %0d: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)", i, g.x, g.y, g.c, exp_q[i].x, exp_q[i].y, exp_q[i].c);
         end
      end
      do_redraw(1, 5, 10, 4, 20, 100, -1, 0, 50);
      checks++; if (acc_q.size() != 0) begin errors++; $display("[TB] FAIL empty count: got %0d expected 0", acc_q.size()); end
      checks++; if (busy_seen != 0) begin errors++; $display("[TB] FAIL empty busy: got %0d expected 0", busy_seen); end
      checks++; if (first_done_cyc != 0) begin errors++; $display("[TB] FAIL empty done timing: got %0d expected 0", first_done_cyc); end
      checks++; if (done_count != 1) begin errors++; $display("[TB] FAIL empty done pulses: got %0d expected 1", done_count); end
      exp_q.delete();
      build_expected(3, 40, 60, 42, 61);
      do_redraw(3, 40, 60, 42, 61, 80, -1, 0, 300);
      checks++; if (acc_q.size() != 6) begin errors++; $display("[TB] FAIL sel3 count: got %0d expected 6", acc_q.size()); end
      foreach (exp_q[i]) begin
         pix_t g;
         g = (i < acc_q.size()) ? acc_q[i] : '1;
         checks++;
         if (g !== exp_q[i]) begin
            errors++;
            $display("[TB] FAIL sel3 pixel %0d: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)", i, g.x, g.y, g.c, exp_q[i].x, exp_q[i].y, exp_q[i].c);
         end
      end
   endtask

   task automatic test_start_while_busy();
      rom_mode = 1;
      exp_q.delete();
      build_expected(2, 20, 20, 29, 24);
      do_redraw(2, 20, 20, 29, 24, 100, 10, 0, 400);
      checks++; if (acc_q.size() != 50) begin errors++; $display("[TB] FAIL busy-start count: got %0d expected 50", acc_q.size()); end
      foreach (exp_q[i]) begin
         pix_t g;
         g = (i < acc_q.size()) ? acc_q[i] : '1;
         checks++;
         if (g !== exp_q[i]) begin
            errors++;
            if (errors <= 10) $display("[TB] FAIL busy-start pixel %0d: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)", i, g.x, g.y, g.c, exp_q[i].x, exp_q[i].y, exp_q[i].c);
         end
      end
      checks++; if (done_count != 1) begin errors++; $display("[TB] FAIL busy-start done pulses: got %0d expected 1", done_count); end
   endtask

   task automatic test_back_to_back();
      rom_mode = 1;
      ch_sel = 2'd2; ch_x0 = 40; ch_y0 = 41; ch_x1 = 42; ch_y1 = 41;
      exp_q.delete();
      build_expected(1, 30, 30, 31, 30);
      build_expected(2, 40, 41, 42, 41);
      do_redraw(1, 30, 30, 31, 30, 100, -1, 1, 300);
      checks++; if (acc_q.size() != 5) begin errors++; $display("[TB] FAIL b2b count: got %0d expected 5", acc_q.size()); end
      foreach (exp_q[i]) begin
         pix_t g;
         g = (i < acc_q.size()) ? acc_q[i] : '1;
         checks++;
         if (g !== exp_q[i]) begin
            errors++;
            $display("[TB] FAIL b2b pixel %0d: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)", i, g.x, g.y, g.c, exp_q[i].x, exp_q[i].y, exp_q[i].c);
         end
      end
      checks++; if (done_count != 2) begin errors++; $display("[TB] FAIL b2b done pulses: got %0d expected 2", done_count); end
   endtask

   task automatic test_reset_mid();
      rom_mode = 1;
      @(negedge clock);
      bg_sel = 2'd1; x0 = 9'd0; y0 = 8'd0; x1 = 9'd50; y1 = 8'd50;
      start = 1'b1; plot_ready = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (20) @(posedge clock);
      #2;
      checks++; if (busy !== 1'b1 || plot !== 1'b1) begin errors++; $display("[TB] FAIL mid-scan activity: got busy=%b plot=%b expected 1 1", busy, plot); end
      #2;
      resetn = 1'b0;
      #1;
      checks++; if (plot !== 1'b0) begin errors++; $display("[TB] FAIL async reset plot: got %b expected 0", plot); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL async reset busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL async reset done: got %b expected 0", done); end
      checks++; if (rom_address !== 17'd0) begin errors++; $display("[TB] FAIL async reset address: got %0d expected 0", rom_address); end
      @(negedge clock);
      resetn = 1'b1;
      exp_q.delete();
      build_expected(1, 7, 3, 9, 4);
      do_redraw(1, 7, 3, 9, 4, 60, -1, 0, 300);
      checks++; if (acc_q.size() != 6) begin errors++; $display("[TB] FAIL post-reset count: got %0d expected 6", acc_q.size()); end
      foreach (exp_q[i]) begin
         pix_t g;
         g = (i < acc_q.size()) ? acc_q[i] : '1;
         checks++;
         if (g !== exp_q[i]) begin
            errors++;
            $display("[TB] FAIL post-reset pixel %0d: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)", i, g.x, g.y, g.c, exp_q[i].x, exp_q[i].y, exp_q[i].c);
         end
      end
   endtask

   task automatic test_random();
      rom_mode = 1;
      for (int n = 0; n < 5; n++) begin
         int sel, rx0, ry0, rx1, ry1, pct;
         sel = int'($urandom_range(3));
         rx0 = int'($urandom_range(319, 1));
         ry0 = int'($urandom_range(239, 1));
         rx1 = rx0 + int'($urandom_range(7)) - 1;
         ry1 = ry0 + int'($urandom_range(6)) - 1;
         pct = int'($urandom_range(100, 30));
         exp_q.delete();
         build_expected(sel, rx0, ry0, rx1, ry1);
         do_redraw(sel, rx0, ry0, rx1, ry1, pct, -1, 0, 2000);
         checks++; if (acc_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL random %0d count: got %0d expected %0d", n, acc_q.size(), exp_q.size()); end
         foreach (exp_q[i]) begin
            pix_t g;
            g = (i < acc_q.size()) ? acc_q[i] : '1;
            checks++;
            if (g !== exp_q[i]) begin
               errors++;
               $display("[TB] FAIL random %0d pixel %0d: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)", n, i, g.x, g.y, g.c, exp_q[i].x, exp_q[i].y, exp_q[i].c);
            end
         end
         checks++; if (stall_err != 0 || clken_err != 0) begin errors++; $display("[TB] FAIL random %0d stall: got %0d/%0d bad cycles expected 0/0", n, stall_err, clken_err); end
         checks++; if (done_count != 1) begin errors++; $display("[TB] FAIL random %0d done pulses: got %0d expected 1", n, done_count); end
      end
   endtask

   initial begin
      test_reset();
      test_region_select();
      test_backpressure();
      test_boundaries();
      test_start_while_busy();
      test_back_to_back();
      test_reset_mid();
      test_random();
      test_full_screen();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
